// File: rtl/lc4_alu_pkg.sv
// Shared LC4 ALU definitions: divider state encoding and the DIV/MOD
// alu_ctl codes so the stall logic and the divider agree on them.
package lc4_alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam logic [15:0] ALU_CTL_DIV = 16'd3;
    localparam logic [15:0] ALU_CTL_MOD = 16'd4;

endpackage

// File: rtl/lc4_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, and record the quotient bit.
module lc4_div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH:0]   r,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   r_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0] r_sh;
    logic [WIDTH:0] r_sub;
    logic           ge;

    // Compare and subtract are WIDTH+1 bits wide so a shifted remainder
    // with its top bit set still compares correctly against the divisor.
    // r[WIDTH] is always 0 between steps; folding it into the compare keeps
    // the whole partial remainder observed without changing the result.
    always_comb begin
        r_sh   = {r[WIDTH-1:0], q[WIDTH-1]};
        r_sub  = r_sh - {1'b0, divisor};
        ge     = r[WIDTH] || (r_sh >= {1'b0, divisor});
        r_next = ge ? r_sub : r_sh;
        q_next = {q[WIDTH-2:0], ge};
    end

endmodule

// File: rtl/lc4_div_sequencer.sv
// Iterative unsigned divide/modulo for the LC4 ALU: one quotient bit per
// cycle, results held in dedicated output registers until the next DONE.
module lc4_div_sequencer
    import lc4_alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int ITERS = WIDTH   // must equal WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             gwe,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder
);

    localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ITERS - 1);

    div_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   r;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH:0]   r_step;
    logic [WIDTH-1:0] q_step;
    logic             load;
    logic             zero_div;
    logic             finish;

    lc4_div_step #(.WIDTH(WIDTH)) u_step (
        .r       (r),
        .q       (q),
        .divisor (dvs),
        .r_next  (r_step),
        .q_next  (q_step)
    );

    assign o_busy = (state == RUN);
    assign o_done = (state == DONE);

    // Next-state decode; a start in DONE is taken directly (no IDLE bubble).
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        zero_div  = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (i_start) begin
                    if (i_divisor != '0) begin
                        state_nxt = RUN;
                        load      = 1'b1;
                    end else begin
                        state_nxt = DONE;
                        zero_div  = 1'b1;
                    end
                end else begin
                    state_nxt = IDLE;
                end
            end
            RUN: begin
                if (cnt == LAST) begin
                    state_nxt = DONE;
                    finish    = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register; gwe low freezes everything, including a pending DONE.
    always_ff @(posedge clk) begin
        if (rst)      state <= IDLE;
        else if (gwe) state <= state_nxt;
    end

    // Working registers: load operands on accept, one restoring step per RUN edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            r   <= '0;
            q   <= '0;
            dvs <= '0;
        end else if (gwe) begin
            if (load) begin
                cnt <= '0;
                r   <= '0;
                q   <= i_dividend;
                dvs <= i_divisor;
            end else if (state == RUN) begin
                cnt <= finish ? '0 : cnt + 1'b1;
                r   <= r_step;
                q   <= q_step;
            end
        end
    end

    // Result registers change only on the edge that enters DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_quotient  <= '0;
            o_remainder <= '0;
        end else if (gwe) begin
            if (finish) begin
                o_quotient  <= q_step;
                o_remainder <= r_step[WIDTH-1:0];
            end else if (zero_div) begin
                o_quotient  <= '0;
                o_remainder <= '0;
            end
        end
    end

endmodule

// File: tb/tb_lc4_div_sequencer.sv
// Self-checking bench for lc4_div_sequencer: directed table, multi-cycle
// corner sequences, and random operands against an arithmetic model.
module tb_lc4_div_sequencer;

    localparam int WIDTH = 16;
    localparam int ITERS = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             gwe;
    logic             i_start;
    logic [WIDTH-1:0] i_dividend;
    logic [WIDTH-1:0] i_divisor;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_quotient;
    logic [WIDTH-1:0] o_remainder;

    int n_chk  = 0;
    int n_fail = 0;

    lc4_div_sequencer #(.WIDTH(WIDTH), .ITERS(ITERS)) dut (
        .clk         (clk),
        .rst         (rst),
        .gwe         (gwe),
        .i_start     (i_start),
        .i_dividend  (i_dividend),
        .i_divisor   (i_divisor),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_quotient  (o_quotient),
        .o_remainder (o_remainder)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] q;
        logic [15:0] r;
        int          lat;
    } vec_t;

    vec_t vecs [9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one divide from IDLE, scramble operands during RUN, and wait
    // (bounded) for o_done. lat counts edges after the accept edge.
    task automatic run_div(input logic [15:0] a, input logic [15:0] b,
                           output logic [15:0] q, output logic [15:0] r,
                           output int lat, output int busy_n);
        i_start    = 1'b1;
        i_dividend = a;
        i_divisor  = b;
        tick();
        i_start    = 1'b0;
        i_dividend = 16'($urandom);
        i_divisor  = 16'($urandom);
        lat    = 0;
        busy_n = 0;
        while (!o_done && lat < 100) begin
            if (o_busy) busy_n++;
            tick();
            lat++;
        end
        q = o_quotient;
        r = o_remainder;
    endtask

    // Reference model: plain arithmetic plus the divide-by-zero convention.
    function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] q, output logic [15:0] r,
                                  output int lat);
        if (b == 0) begin
            q = 0; r = 0; lat = 0;
        end else begin
            q = a / b; r = a % b; lat = ITERS;
        end
    endfunction

    initial begin
        logic [15:0] q, r, eq, er, a, b;
        int lat, busy_n, elat, n, dones;
        bit ok;

        vecs[0] = '{16'd100,   16'd7,      16'd14,    16'd2,      16};
        vecs[1] = '{16'd42,    16'd0,      16'd0,     16'd0,      0};
        vecs[2] = '{16'hFFFF,  16'h0001,   16'hFFFF,  16'h0000,   16};
        vecs[3] = '{16'h1234,  16'hFFFF,   16'h0000,  16'h1234,   16};
        vecs[4] = '{16'hFFFF,  16'h8001,   16'h0001,  16'h7FFE,   16};
        vecs[5] = '{16'hFFFF,  16'hFFFF,   16'h0001,  16'h0000,   16};
        vecs[6] = '{16'd1000,  16'd33,     16'd30,    16'd10,     16};
        vecs[7] = '{16'd5,     16'd0,      16'd0,     16'd0,      0};
        vecs[8] = '{16'd9,     16'd3,      16'd3,     16'd0,      16};

        rst = 1'b1; gwe = 1'b1; i_start = 1'b0; i_dividend = '0; i_divisor = '0;
        tick(); tick();
        rst = 1'b0;
        chk("reset_busy", 32'(o_busy), 0);
        chk("reset_done", 32'(o_done), 0);
        chk("reset_q",    32'(o_quotient), 0);
        chk("reset_r",    32'(o_remainder), 0);

        // Directed table
        foreach (vecs[i]) begin
            run_div(vecs[i].a, vecs[i].b, q, r, lat, busy_n);
            chk($sformatf("vec%0d_q", i),    32'(q), 32'(vecs[i].q));
            chk($sformatf("vec%0d_r", i),    32'(r), 32'(vecs[i].r));
            chk($sformatf("vec%0d_lat", i),  32'(lat), 32'(vecs[i].lat));
            chk($sformatf("vec%0d_busy", i), 32'(busy_n), 32'(vecs[i].lat));
            tick();
            chk($sformatf("vec%0d_pulse", i), {30'd0, o_done, o_busy}, 0);
            chk($sformatf("vec%0d_hold", i), {o_quotient, o_remainder}, {vecs[i].q, vecs[i].r});
        end

        // Back-to-back: start held throughout, mid-RUN operand change ignored
        i_start = 1'b1; i_dividend = 16'd100; i_divisor = 16'd7;
        tick();
        i_dividend = 16'd999; i_divisor = 16'd5;
        lat = 0;
        while (!o_done && lat < 100) begin tick(); lat++; end
        chk("b2b_first_lat", 32'(lat), 16);
        chk("b2b_first_res", {o_quotient, o_remainder}, {16'd14, 16'd2});
        i_dividend = 16'd50; i_divisor = 16'd6;
        tick();
        chk("b2b_no_bubble", {30'd0, o_busy, o_done}, 32'b10);
        i_start = 1'b0;
        n = 1;
        while (!o_done && n < 100) begin tick(); n++; end
        chk("b2b_gap", 32'(n), 17);
        chk("b2b_second_res", {o_quotient, o_remainder}, {16'd8, 16'd2});
        tick();

        // gwe low for 5 cycles mid-RUN, then freeze a pending DONE
        i_start = 1'b1; i_dividend = 16'd1000; i_divisor = 16'd33;
        tick();
        i_start = 1'b0;
        repeat (4) tick();
        gwe = 1'b0; ok = 1'b1;
        repeat (5) begin tick(); if (!o_busy || o_done) ok = 1'b0; end
        chk("gwe_freeze_run", 32'(ok), 1);
        gwe = 1'b1;
        lat = 0;
        while (!o_done && lat < 100) begin tick(); lat++; end
        chk("gwe_remaining_lat", 32'(lat), 12);
        chk("gwe_res", {o_quotient, o_remainder}, {16'd30, 16'd10});
        gwe = 1'b0;
        repeat (3) tick();
        chk("gwe_done_held", 32'(o_done), 1);
        gwe = 1'b1;
        tick();
        chk("gwe_done_release", {30'd0, o_done, o_busy}, 0);

        // Reset at iteration 8 abandons the operation
        i_start = 1'b1; i_dividend = 16'd100; i_divisor = 16'd7;
        tick();
        i_start = 1'b0;
        repeat (8) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_outs", {o_busy, o_done, o_quotient, o_remainder}, 0);
        dones = 0;
        repeat (20) begin tick(); if (o_done || o_busy) dones++; end
        chk("midrst_quiet", 32'(dones), 0);
        run_div(16'd9, 16'd3, q, r, lat, busy_n);
        chk("midrst_after", {q, r}, {16'd3, 16'd0});
        tick();

        // Random operands vs. arithmetic model
        for (int k = 0; k < 40; k++) begin
            a = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       b = 16'd0;
                1:       b = 16'($urandom_range(1, 15));
                default: b = 16'($urandom);
            endcase
            model(a, b, eq, er, elat);
            run_div(a, b, q, r, lat, busy_n);
            chk($sformatf("rnd%0d_%0h/%0h", k, a, b), {q, r}, {eq, er});
            chk($sformatf("rnd%0d_lat", k), 32'(lat), 32'(elat));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
